// File: rtl/tbus_mem_responder.sv
// tbus_mem_responder: single-outstanding, fixed-latency tbus memory target
// with a 64-bit word store and bit-granular write mask.
module tbus_mem_responder #(
    parameter int DEPTH     = 4096,
    parameter int LATENCY   = 2,
    parameter int READY_GAP = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tbus_index_valid,
    output logic        tbus_index_ready,
    input  logic [63:0] tbus_index,
    input  logic [63:0] tbus_write_data,
    input  logic [63:0] tbus_write_mask,
    input  logic [1:0]  tbus_operation_type,
    output logic [63:0] tbus_read_data,
    output logic        tbus_operation_done
);
    localparam logic [1:0] TBUS_WRITE = 2'd2;
    localparam int AW = $clog2(DEPTH);

    if (LATENCY < 1 || LATENCY > 15 || READY_GAP < 0 || READY_GAP > 7 || (1 << AW) != DEPTH) begin : g_bad_params
        $error("tbus_mem_responder: illegal parameter value");
    end

    typedef enum logic [1:0] {IDLE, WAIT, DONE, GAP} state_t;

    state_t          state;
    logic [3:0]      cnt;
    logic [2:0]      gcnt;
    logic [AW-1:0]   word_q;
    logic            wr_q;
    logic [63:0]     data_q;
    logic [63:0]     mask_q;
    logic [63:0]     mem [DEPTH];
    logic            fire;
    logic            go_done;
    logic            wr;
    logic [AW-1:0]   word;
    logic [63:0]     data;
    logic [63:0]     mask;
    logic            unused_bits;

    assign unused_bits = ^{tbus_index[63:AW+3], tbus_index[2:0]};
    assign fire    = tbus_index_valid & tbus_index_ready;
    // With LATENCY=1 the commit happens on the fire edge, so take the live inputs in IDLE
    assign word    = state == IDLE ? tbus_index[AW+2:3] : word_q;
    assign data    = state == IDLE ? tbus_write_data : data_q;
    assign mask    = state == IDLE ? tbus_write_mask : mask_q;
    assign wr      = state == IDLE ? tbus_operation_type == TBUS_WRITE : wr_q;
    assign go_done = !reset && (state == IDLE ? fire && LATENCY == 1 : state == WAIT && cnt == 4'd1);

    always_ff @(posedge clock) begin
        if (go_done && wr)
            mem[word] <= (mem[word] & ~mask) | (data & mask);
        tbus_read_data <= go_done && !wr ? mem[word] : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state               <= IDLE;
            tbus_index_ready    <= 1'b1;
            tbus_operation_done <= 1'b0;
            cnt                 <= '0;
            gcnt                <= '0;
        end else begin
            case (state)
                IDLE: if (fire) begin
                    word_q           <= tbus_index[AW+2:3];
                    wr_q             <= tbus_operation_type == TBUS_WRITE;
                    data_q           <= tbus_write_data;
                    mask_q           <= tbus_write_mask;
                    cnt              <= 4'(LATENCY - 1);
                    tbus_index_ready <= 1'b0;
                    state            <= LATENCY == 1 ? DONE : WAIT;
                    tbus_operation_done <= LATENCY == 1;
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state               <= DONE;
                        tbus_operation_done <= 1'b1;
                    end
                end
                DONE: begin
                    tbus_operation_done <= 1'b0;
                    gcnt                <= 3'(READY_GAP);
                    state               <= READY_GAP > 0 ? GAP : IDLE;
                    tbus_index_ready    <= READY_GAP == 0;
                end
                GAP: begin
                    gcnt <= gcnt - 3'd1;
                    if (gcnt == 3'd1) begin
                        state            <= IDLE;
                        tbus_index_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tbus_mem_responder.sv
// tb_tbus_mem_responder: drives four responder configurations and checks
// them against a word-array reference model of the tbus memory.
module tb_tbus_mem_responder;
    localparam int N = 4;
    localparam int LATS [N] = '{2, 2, 1, 15};
    localparam int GAPS [N] = '{0, 2, 0, 3};
    localparam logic [1:0] OP_RD = 2'd1;
    localparam logic [1:0] OP_WR = 2'd2;

    logic        clock = 1'b0;
    logic        reset [N];
    logic        valid [N];
    logic        ready [N];
    logic        done  [N];
    logic [63:0] index [N];
    logic [63:0] wdata [N];
    logic [63:0] mask  [N];
    logic [63:0] rdata [N];
    logic [1:0]  op    [N];

    logic [63:0] mdl [N][4096];
    int          winit [N][8];
    int          tests = 0;
    int          fails = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < N; g++) begin : g_dut
        tbus_mem_responder #(.DEPTH(4096), .LATENCY(LATS[g]), .READY_GAP(GAPS[g])) u_dut (
            .clock               (clock),
            .reset               (reset[g]),
            .tbus_index_valid    (valid[g]),
            .tbus_index_ready    (ready[g]),
            .tbus_index          (index[g]),
            .tbus_write_data     (wdata[g]),
            .tbus_write_mask     (mask[g]),
            .tbus_operation_type (op[g]),
            .tbus_read_data      (rdata[g]),
            .tbus_operation_done (done[g])
        );
    end

    // One complete request on instance k; model updated, latency/data checked.
    task automatic req(input int k, input logic [1:0] o, input logic [63:0] a, input logic [63:0] d,
                       input logic [63:0] m, output logic [63:0] got);
        int n;
        int lat;
        int w;
        logic [63:0] exp;
        w = int'(a[14:3]);
        got = '0;
        @(negedge clock);
        valid[k] = 1'b1; op[k] = o; index[k] = a; wdata[k] = d; mask[k] = m;
        n = 0;
        while (!ready[k] && n < 100) begin
            @(negedge clock);
            n++;
        end
        tests++;
        if (!ready[k]) begin
            fails++;
            $display("FAIL ready_timeout inst=%0d ready=%0b required 1", k, ready[k]);
            valid[k] = 1'b0;
            return;
        end
        exp = o == OP_WR ? 64'd0 : mdl[k][w];
        if (o == OP_WR) mdl[k][w] = (mdl[k][w] & ~m) | (d & m);
        @(posedge clock);
        #1;
        valid[k] = 1'($urandom_range(0, 1));
        index[k] = {$urandom, $urandom};
        op[k] = 2'($urandom_range(0, 3));
        wdata[k] = {$urandom, $urandom};
        mask[k] = {$urandom, $urandom};
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
            if (!done[k]) begin
                tests++;
                if (rdata[k] !== 64'd0) begin
                    fails++;
                    $display("FAIL idle_rdata inst=%0d got=%h required 0", k, rdata[k]);
                end
            end
        end while (!done[k] && lat < 40);
        valid[k] = 1'b0;
        got = rdata[k];
        tests += 3;
        if (lat !== LATS[k]) begin
            fails++;
            $display("FAIL latency inst=%0d got=%0d required %0d", k, lat, LATS[k]);
        end
        if (ready[k] !== 1'b0) begin
            fails++;
            $display("FAIL ready_in_done inst=%0d got=%0b required 0", k, ready[k]);
        end
        if (rdata[k] !== exp) begin
            fails++;
            $display("FAIL rdata inst=%0d op=%0d word=%0d got=%h required %h", k, o, w, rdata[k], exp);
        end
        @(negedge clock);
        tests++;
        if (done[k] !== 1'b0) begin
            fails++;
            $display("FAIL done_width inst=%0d got=%0b required 0", k, done[k]);
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < N; k++) begin
            reset[k] = 1'b1; valid[k] = 1'b0; op[k] = OP_RD;
            index[k] = '0; wdata[k] = '0; mask[k] = '0;
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        for (int k = 0; k < N; k++) reset[k] = 1'b0;
        repeat (4) begin
            @(negedge clock);
            for (int k = 0; k < N; k++) begin
                tests++;
                if (ready[k] !== 1'b1 || done[k] !== 1'b0 || rdata[k] !== 64'd0) begin
                    fails++;
                    $display("FAIL reset_state inst=%0d ready=%0b done=%0b rdata=%h required 1/0/0",
                             k, ready[k], done[k], rdata[k]);
                end
            end
        end
    endtask

    task automatic test_directed();
        logic [63:0] got;
        req(0, OP_WR, 64'h8000_1008, 64'h1122334455667788, '1, got);
        req(0, OP_RD, 64'h8000_1008, '0, '0, got);
        tests++;
        if (got !== 64'h1122334455667788) begin
            fails++;
            $display("FAIL full_write got=%h required 1122334455667788", got);
        end
        req(0, OP_WR, 64'h8000_1008, 64'hAB << 40, 64'hFF << 40, got);
        req(0, OP_RD, 64'h8000_1008, '0, '0, got);
        tests++;
        if (got !== 64'h1122AB4455667788) begin
            fails++;
            $display("FAIL masked_write got=%h required 1122ab4455667788", got);
        end
        req(0, OP_WR, 64'h8000_1008, 64'hFFFF_FFFF_FFFF_FFFF, '0, got);
        req(0, OP_RD, 64'h0000_1008, '0, '0, got);
        tests++;
        if (got !== 64'h1122AB4455667788) begin
            fails++;
            $display("FAIL zero_mask got=%h required 1122ab4455667788", got);
        end
    endtask

    task automatic test_random(input int k);
        logic [63:0] got;
        logic [63:0] a;
        logic [63:0] m;
        int w;
        for (int i = 0; i < 8; i++) begin
            winit[k][i] = $urandom_range(0, 4095);
            req(k, OP_WR, 64'(winit[k][i]) << 3, {$urandom, $urandom}, '1, got);
        end
        for (int i = 0; i < 20; i++) begin
            w = winit[k][$urandom_range(0, 7)];
            a = ({$urandom, $urandom} & ~(64'hFFF << 3)) | (64'(w) << 3);
            case ($urandom_range(0, 2))
                0: m = '0;
                1: m = '1;
                default: m = {$urandom, $urandom};
            endcase
            req(k, 2'($urandom_range(0, 3)), a, {$urandom, $urandom}, m, got);
        end
    endtask

    task automatic test_back_to_back();
        int fire_at [$];
        int dones = 0;
        int w = winit[1][0];
        @(negedge clock);
        valid[1] = 1'b1; op[1] = OP_RD; index[1] = 64'(w) << 3;
        for (int c = 0; c < 50; c++) begin
            if (ready[1]) fire_at.push_back(c);
            if (done[1]) begin
                dones++;
                tests += 2;
                if (ready[1] !== 1'b0) begin
                    fails++;
                    $display("FAIL b2b_ready_in_done got=%0b required 0", ready[1]);
                end
                if (rdata[1] !== mdl[1][w]) begin
                    fails++;
                    $display("FAIL b2b_rdata got=%h required %h", rdata[1], mdl[1][w]);
                end
            end
            @(negedge clock);
        end
        valid[1] = 1'b0;
        repeat (10) begin
            if (done[1]) dones++;
            @(negedge clock);
        end
        for (int i = 1; i < fire_at.size(); i++) begin
            tests++;
            if (fire_at[i] - fire_at[i-1] != 1 + LATS[1] + GAPS[1]) begin
                fails++;
                $display("FAIL b2b_spacing got=%0d required %0d", fire_at[i] - fire_at[i-1], 1 + LATS[1] + GAPS[1]);
            end
        end
        tests += 2;
        if (fire_at.size() < 9) begin
            fails++;
            $display("FAIL b2b_fire_count got=%0d required >=9", fire_at.size());
        end
        if (dones != fire_at.size()) begin
            fails++;
            $display("FAIL b2b_done_count got=%0d required %0d", dones, fire_at.size());
        end
    endtask

    task automatic test_reset_midop();
        logic [63:0] got;
        logic [63:0] prior;
        int n;
        prior = {$urandom, $urandom};
        req(0, OP_WR, 64'd40, prior, '1, got);
        @(negedge clock);
        valid[0] = 1'b1; op[0] = OP_WR; index[0] = 64'd40; wdata[0] = 64'hDEAD; mask[0] = '1;
        n = 0;
        while (!ready[0] && n < 20) begin
            @(negedge clock);
            n++;
        end
        @(posedge clock);
        #1;
        valid[0] = 1'b0;
        reset[0] = 1'b1;
        @(posedge clock);
        #1;
        reset[0] = 1'b0;
        @(negedge clock);
        tests++;
        if (ready[0] !== 1'b1) begin
            fails++;
            $display("FAIL ready_after_reset got=%0b required 1", ready[0]);
        end
        repeat (4) begin
            tests++;
            if (done[0] !== 1'b0) begin
                fails++;
                $display("FAIL done_after_reset got=%0b required 0", done[0]);
            end
            @(negedge clock);
        end
        req(0, OP_RD, 64'd40, '0, '0, got);
        tests++;
        if (got !== prior) begin
            fails++;
            $display("FAIL reset_discard got=%h required %h", got, prior);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        for (int k = 0; k < N; k++) test_random(k);
        test_back_to_back();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
